trap_controller: RTL and testbench

- Initiating side of the exception interface into the CSR unit.
- Watches retiring-instruction exception flags, `mret` and the external interrupt line, and arbitrates by priority.
- Drives one-cycle exception requests (cause, faulting PC) to the CSR unit, stalls the pipeline, then redirects fetch to the trap vector or to `mepc`.
- Sits between the controller/datapath and `csrUnit`.

---
 rtl/riscV_unrn_pkg.sv | 29 ++
 rtl/trap_controller_sync_bit.sv | 33 +++
 rtl/trap_controller.sv | 195 +++++++++++++++++++
 tb/tb_trap_controller.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscV_unrn_pkg.sv
// -----------------------------------------------------------------------------
// riscV_unrn_pkg
//   Shared types and constants for the trap path between the pipeline
//   controller and the CSR unit.
//
//   trap_state_t        : sequencing states of trap_controller
//   EXC_* / IRQ_M_EXT   : mcause values (RV32 layout, bit 31 = interrupt)
//   MTVEC_MODE_VECTORED : mtvec[1:0] encoding for vectored interrupt dispatch
// -----------------------------------------------------------------------------
package riscV_unrn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,  // watching the retire stage
    ST_TRAP     = 2'd1,  // exception request presented to the CSR unit
    ST_REDIRECT = 2'd2,  // fetch redirected to the trap vector
    ST_RET      = 2'd3   // mret pulse + redirect to mepc
  } trap_state_t;

  // Cause values in 32-bit form; trap_controller widens them to XLEN by moving
  // bit 31 (interrupt flag) to the top bit of the datapath.
  localparam logic [31:0] EXC_INSTR_MISALIGNED = 32'd0;
  localparam logic [31:0] EXC_ILLEGAL          = 32'd2;
  localparam logic [31:0] EXC_BREAKPOINT       = 32'd3;
  localparam logic [31:0] EXC_ECALL_M          = 32'd11;
  localparam logic [31:0] IRQ_M_EXT            = 32'h8000_000B;

  localparam logic [1:0]  MTVEC_MODE_VECTORED  = 2'b01;

endpackage

// File: rtl/trap_controller_sync_bit.sv
// -----------------------------------------------------------------------------
// sync_bit
//   Single-bit flop-chain synchroniser for an asynchronous level input.
//   STAGES must be at least 2; the output is the input delayed by STAGES
//   clock edges once metastability has resolved.
//
//   clk  : destination clock
//   rst  : synchronous active-high clear of the whole chain
//   d_i  : asynchronous input
//   q_o  : synchronised output (last flop of the chain)
// -----------------------------------------------------------------------------
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/trap_controller.sv
// -----------------------------------------------------------------------------
// trap_controller
//   Initiating side of the exception interface into the CSR unit. Watches the
//   retiring instruction's exception flags, mret and the external interrupt,
//   picks the highest-priority event, issues a one-cycle exception request
//   (cause + faulting PC) or mret pulse, stalls the pipeline for the duration
//   of the sequence and redirects fetch to the trap vector or to mepc.
//
//   Sequences (N = cycle the event is accepted in IDLE):
//     trap : N stall, N+1 excRequest_o, N+2 redirect_o to trap target
//     mret : N stall, N+1 mret_o + redirect_o to mepc
//
//   Ports
//     clk, rst            : clock, synchronous active-high reset
//     valid_i, pc_i       : retiring instruction and its PC
//     instr_misaligned_i, illegal_i, ebreak_i, ecall_i, mret_i
//                         : decode/exception flags, qualified by valid_i
//     ext_irq_i           : asynchronous level external interrupt
//     mstatus_mie_i, mie_meie_i, mtvec_i, mepc_i
//                         : CSR state from the CSR unit
//     excRequest_o, excCause_o, excPc_o, mret_o
//                         : requests towards the CSR unit
//     stall_o             : hold pipeline / block commit
//     redirect_o, redirect_pc_o
//                         : fetch redirect strobe and target
// -----------------------------------------------------------------------------
import riscV_unrn_pkg::*;

module trap_controller #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic            instr_misaligned_i,
  input  logic            illegal_i,
  input  logic            ebreak_i,
  input  logic            ecall_i,
  input  logic            mret_i,
  input  logic            ext_irq_i,
  input  logic            mstatus_mie_i,
  input  logic            mie_meie_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            excRequest_o,
  output logic [XLEN-1:0] excCause_o,
  output logic [XLEN-1:0] excPc_o,
  output logic            mret_o,
  output logic            stall_o,
  output logic            redirect_o,
  output logic [XLEN-1:0] redirect_pc_o
);

  // Widen a 32-bit package cause to XLEN: interrupt flag goes to the MSB,
  // the exception code stays in the low bits.
  function automatic logic [XLEN-1:0] widen_cause(input logic [31:0] c);
    logic [XLEN-1:0] r;
    r          = '0;
    r[30:0]    = c[30:0];
    r[XLEN-1]  = c[31];
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // Interrupt synchroniser and event qualification
  // ---------------------------------------------------------------------------
  logic irq_sync;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_irq_sync (
    .clk (clk),
    .rst (rst),
    .d_i (ext_irq_i),
    .q_o (irq_sync)
  );

  logic            irq_take;
  logic            trap_any;
  logic            mret_take;
  logic [XLEN-1:0] cause_d;

  // Interrupts only at an instruction boundary, so they also need valid_i.
  assign irq_take = irq_sync & mstatus_mie_i & mie_meie_i & valid_i;

  assign trap_any = irq_take
                  | (valid_i & (instr_misaligned_i | illegal_i | ebreak_i | ecall_i));

  // mret is the lowest priority event: any trap in the same cycle suppresses it.
  assign mret_take = valid_i & mret_i & ~trap_any;

  always_comb begin
    cause_d = '0;
    if (irq_take)                       cause_d = widen_cause(IRQ_M_EXT);
    else if (valid_i && instr_misaligned_i) cause_d = widen_cause(EXC_INSTR_MISALIGNED);
    else if (valid_i && illegal_i)      cause_d = widen_cause(EXC_ILLEGAL);
    else if (valid_i && ebreak_i)       cause_d = widen_cause(EXC_BREAKPOINT);
    else if (valid_i && ecall_i)        cause_d = widen_cause(EXC_ECALL_M);
  end

  // ---------------------------------------------------------------------------
  // Sequencer with registered request outputs
  // ---------------------------------------------------------------------------
  trap_state_t     state_q;
  logic [XLEN-1:0] cause_q;      // kept past TRAP for the vectored target
  logic            exc_req_q;
  logic [XLEN-1:0] exc_cause_q;
  logic [XLEN-1:0] exc_pc_q;
  logic            mret_q;
  logic            redirect_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cause_q     <= '0;
      exc_req_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_pc_q    <= '0;
      mret_q      <= 1'b0;
      redirect_q  <= 1'b0;
    end else begin
      // Pulses and TRAP-only payload default low every cycle.
      exc_req_q   <= 1'b0;
      exc_cause_q <= '0;
      exc_pc_q    <= '0;
      mret_q      <= 1'b0;
      redirect_q  <= 1'b0;

      unique case (state_q)
        ST_IDLE: begin
          if (trap_any) begin
            state_q     <= ST_TRAP;
            cause_q     <= cause_d;
            exc_req_q   <= 1'b1;
            exc_cause_q <= cause_d;
            exc_pc_q    <= pc_i;
          end else if (mret_take) begin
            state_q    <= ST_RET;
            mret_q     <= 1'b1;
            redirect_q <= 1'b1;
          end
        end
        ST_TRAP: begin
          state_q    <= ST_REDIRECT;
          redirect_q <= 1'b1;
        end
        ST_REDIRECT: state_q <= ST_IDLE;
        ST_RET:      state_q <= ST_IDLE;
        default:     state_q <= ST_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Redirect target. mtvec_i and mepc_i are read in the redirect cycle itself
  // so a CSR write that lands during TRAP is honoured.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] mtvec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] trap_target;
  logic [XLEN-1:0] redirect_pc_d;

  always_comb begin
    mtvec_base  = {mtvec_i[XLEN-1:2], 2'b00};
    vec_off     = {1'b0, cause_q[XLEN-2:0]} << 2;
    trap_target = mtvec_base;
    if ((mtvec_i[1:0] == MTVEC_MODE_VECTORED) && cause_q[XLEN-1]) begin
      trap_target = mtvec_base + vec_off;  // wraps modulo 2^XLEN
    end

    redirect_pc_d = '0;
    unique case (state_q)
      ST_REDIRECT: redirect_pc_d = trap_target;
      ST_RET:      redirect_pc_d = {mepc_i[XLEN-1:2], 2'b00};
      default:     redirect_pc_d = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  // Stall is combinational in the accepting cycle so the trapping instruction
  // never commits; it stays high for the rest of the sequence.
  assign stall_o = ~rst & ((state_q != ST_IDLE) | trap_any | (valid_i & mret_i));

  assign excRequest_o  = exc_req_q;
  assign excCause_o    = exc_cause_q;
  assign excPc_o       = exc_pc_q;
  assign mret_o        = mret_q;
  assign redirect_o    = redirect_q;
  assign redirect_pc_o = redirect_pc_d;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam int XLEN = 32;
  localparam int SYNC = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic            valid_i;
  logic [XLEN-1:0] pc_i;
  logic            instr_misaligned_i, illegal_i, ebreak_i, ecall_i, mret_i;
  logic            ext_irq_i, mstatus_mie_i, mie_meie_i;
  logic [XLEN-1:0] mtvec_i, mepc_i;
  logic            excRequest_o, mret_o, stall_o, redirect_o;
  logic [XLEN-1:0] excCause_o, excPc_o, redirect_pc_o;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  trap_controller #(.XLEN(XLEN), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .pc_i(pc_i),
    .instr_misaligned_i(instr_misaligned_i), .illegal_i(illegal_i),
    .ebreak_i(ebreak_i), .ecall_i(ecall_i), .mret_i(mret_i),
    .ext_irq_i(ext_irq_i), .mstatus_mie_i(mstatus_mie_i), .mie_meie_i(mie_meie_i),
    .mtvec_i(mtvec_i), .mepc_i(mepc_i),
    .excRequest_o(excRequest_o), .excCause_o(excCause_o), .excPc_o(excPc_o),
    .mret_o(mret_o), .stall_o(stall_o), .redirect_o(redirect_o),
    .redirect_pc_o(redirect_pc_o)
  );

  // Expected behaviour for one future cycle of a sequence.
  typedef struct packed {
    logic        req;
    logic        mret;
    logic        redir;
    logic        is_ret;
    logic [31:0] cause;
    logic [31:0] epc;
  } exp_t;

  task automatic nxt();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    valid_i = 0; pc_i = '0; instr_misaligned_i = 0; illegal_i = 0;
    ebreak_i = 0; ecall_i = 0; mret_i = 0;
  endtask

  task automatic test_reset();
    rst = 1; idle_inputs();
    ext_irq_i = 0; mstatus_mie_i = 0; mie_meie_i = 0; mtvec_i = '0; mepc_i = '0;
    repeat (3) nxt();
    rst = 0; #1;
    checks++;
    if ({excRequest_o, excCause_o, excPc_o, mret_o, stall_o, redirect_o, redirect_pc_o} !== '0) begin
      failures++;
      $display("FAIL reset_outputs req=%0b cause=%0h epc=%0h mret=%0b stall=%0b redir=%0b rpc=%0h want all 0",
               excRequest_o, excCause_o, excPc_o, mret_o, stall_o, redirect_o, redirect_pc_o);
    end
  endtask

  task automatic test_illegal();
    nxt(); valid_i = 1; pc_i = 32'h100; illegal_i = 1; mtvec_i = 32'h200; #1;
    checks++;
    if (stall_o !== 1'b1 || excRequest_o !== 1'b0) begin
      failures++; $display("FAIL illegal_N stall=%0b req=%0b want stall=1 req=0", stall_o, excRequest_o);
    end
    nxt(); idle_inputs(); #1;
    checks++;
    if (excRequest_o !== 1'b1 || excCause_o !== 32'd2 || excPc_o !== 32'h100 || stall_o !== 1'b1 || redirect_o !== 1'b0) begin
      failures++; $display("FAIL illegal_N1 req=%0b cause=%0h epc=%0h stall=%0b redir=%0b want 1/2/100/1/0",
                           excRequest_o, excCause_o, excPc_o, stall_o, redirect_o);
    end
    nxt(); #1;
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200 || excRequest_o !== 1'b0 || excCause_o !== '0 || excPc_o !== '0) begin
      failures++; $display("FAIL illegal_N2 redir=%0b rpc=%0h req=%0b cause=%0h epc=%0h want 1/200/0/0/0",
                           redirect_o, redirect_pc_o, excRequest_o, excCause_o, excPc_o);
    end
    nxt(); #1;
    checks++;
    if (stall_o !== 1'b0 || redirect_o !== 1'b0 || excRequest_o !== 1'b0 || redirect_pc_o !== '0) begin
      failures++; $display("FAIL illegal_N3 stall=%0b redir=%0b req=%0b rpc=%0h want idle",
                           stall_o, redirect_o, excRequest_o, redirect_pc_o);
    end
  endtask

  task automatic test_arbitration();
    int nreq;
    int nmret;
    logic [31:0] c;
    nreq = 0; nmret = 0; c = '0;
    nxt(); valid_i = 1; pc_i = 32'h44; illegal_i = 1; ecall_i = 1; mret_i = 1; #1;
    nxt(); idle_inputs();
    repeat (4) begin
      #1;
      if (excRequest_o) begin nreq++; c = excCause_o; end
      if (mret_o) nmret++;
      nxt();
    end
    checks++;
    if (nreq != 1 || c !== 32'd2) begin
      failures++; $display("FAIL arbitration_cause requests=%0d cause=%0h want 1 request cause 2", nreq, c);
    end
    checks++;
    if (nmret != 0) begin
      failures++; $display("FAIL arbitration_mret mret pulses=%0d want 0", nmret);
    end
  endtask

  task automatic test_vectored_irq();
    logic [31:0] mt;
    logic [31:0] exp_pc;
    int bad;
    bad = 0;
    mstatus_mie_i = 1; mie_meie_i = 1; ext_irq_i = 1; mtvec_i = 32'h301;
    // No instruction retiring: interrupt must wait for a boundary.
    repeat (4) begin nxt(); #1; if (stall_o !== 1'b0 || excRequest_o !== 1'b0) bad++; end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL irq_no_boundary busy cycles=%0d want 0", bad); end
    for (int k = 0; k < 2; k++) begin
      mt     = (k == 0) ? 32'h301 : 32'h300;
      exp_pc = (k == 0) ? 32'h32C : 32'h300;
      // Garbage mtvec during accept/TRAP; the real value arrives in REDIRECT.
      nxt(); valid_i = 1; pc_i = 32'h80 + 32'(k * 4); mtvec_i = 32'hFFFF_FF00; #1;
      checks++;
      if (stall_o !== 1'b1) begin failures++; $display("FAIL irq_stall_%0d stall=%0b want 1", k, stall_o); end
      nxt(); valid_i = 0; #1;
      checks++;
      if (excRequest_o !== 1'b1 || excCause_o !== 32'h8000_000B || excPc_o !== 32'h80 + 32'(k * 4)) begin
        failures++; $display("FAIL irq_req_%0d req=%0b cause=%0h epc=%0h want 1/8000000b/%0h",
                             k, excRequest_o, excCause_o, excPc_o, 32'h80 + 32'(k * 4));
      end
      nxt(); mtvec_i = mt; #1;
      checks++;
      if (redirect_o !== 1'b1 || redirect_pc_o !== exp_pc) begin
        failures++; $display("FAIL irq_target_%0d redir=%0b rpc=%0h want 1/%0h", k, redirect_o, redirect_pc_o, exp_pc);
      end
    end
    ext_irq_i = 0;
    repeat (4) nxt();
  endtask

  task automatic test_masked();
    int bad;
    bad = 0;
    mstatus_mie_i = 0; mie_meie_i = 1; ext_irq_i = 1; mtvec_i = 32'h200;
    repeat (20) begin
      nxt(); valid_i = 1; pc_i = $urandom & 32'hFFFF_FFFC; #1;
      if (stall_o !== 1'b0 || excRequest_o !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin failures++; $display("FAIL masked_irq busy cycles=%0d want 0", bad); end
    nxt(); valid_i = 1; pc_i = 32'h500; mstatus_mie_i = 1; #1;
    checks++;
    if (stall_o !== 1'b1) begin failures++; $display("FAIL unmask_stall stall=%0b want 1", stall_o); end
    nxt(); valid_i = 0; #1;
    checks++;
    if (excRequest_o !== 1'b1 || excCause_o !== 32'h8000_000B || excPc_o !== 32'h500) begin
      failures++; $display("FAIL unmask_req req=%0b cause=%0h epc=%0h want 1/8000000b/500",
                           excRequest_o, excCause_o, excPc_o);
    end
    nxt(); #1;
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h200) begin
      failures++; $display("FAIL unmask_target redir=%0b rpc=%0h want 1/200", redirect_o, redirect_pc_o);
    end
    ext_irq_i = 0; mstatus_mie_i = 0; mie_meie_i = 0;
    repeat (4) nxt();
  endtask

  task automatic test_return();
    nxt(); valid_i = 1; pc_i = 32'h200; mret_i = 1; mepc_i = 32'h106; #1;
    checks++;
    if (stall_o !== 1'b1 || mret_o !== 1'b0) begin
      failures++; $display("FAIL ret_N stall=%0b mret=%0b want 1/0", stall_o, mret_o);
    end
    nxt(); idle_inputs(); #1;
    checks++;
    if (mret_o !== 1'b1 || redirect_o !== 1'b1 || redirect_pc_o !== 32'h104 || excRequest_o !== 1'b0) begin
      failures++; $display("FAIL ret_N1 mret=%0b redir=%0b rpc=%0h req=%0b want 1/1/104/0",
                           mret_o, redirect_o, redirect_pc_o, excRequest_o);
    end
    nxt(); #1;
    checks++;
    if (mret_o !== 1'b0 || redirect_o !== 1'b0 || stall_o !== 1'b0) begin
      failures++; $display("FAIL ret_N2 mret=%0b redir=%0b stall=%0b want 0/0/0", mret_o, redirect_o, stall_o);
    end
  endtask

  task automatic test_reset_mid();
    nxt(); valid_i = 1; ecall_i = 1; pc_i = 32'h300; #1;
    nxt(); idle_inputs(); rst = 1; #1;
    checks++;
    if (excRequest_o !== 1'b1) begin failures++; $display("FAIL rstmid_trap req=%0b want 1", excRequest_o); end
    for (int i = 0; i < 2; i++) begin
      nxt(); rst = 0; #1;
      checks++;
      if ({excRequest_o, excCause_o, excPc_o, mret_o, stall_o, redirect_o, redirect_pc_o} !== '0) begin
        failures++; $display("FAIL rstmid_after_%0d req=%0b cause=%0h redir=%0b rpc=%0h stall=%0b want all 0",
                             i, excRequest_o, excCause_o, redirect_o, redirect_pc_o, stall_o);
      end
    end
    nxt(); valid_i = 1; ecall_i = 1; pc_i = 32'h40; mtvec_i = 32'h300; #1;
    nxt(); idle_inputs(); #1;
    checks++;
    if (excRequest_o !== 1'b1 || excCause_o !== 32'd11 || excPc_o !== 32'h40) begin
      failures++; $display("FAIL rstmid_ecall req=%0b cause=%0h epc=%0h want 1/b/40", excRequest_o, excCause_o, excPc_o);
    end
    nxt(); #1;
    checks++;
    if (redirect_o !== 1'b1 || redirect_pc_o !== 32'h300) begin
      failures++; $display("FAIL rstmid_target redir=%0b rpc=%0h want 1/300", redirect_o, redirect_pc_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [8:0] reqs;
    int nstall;
    reqs = '0; nstall = 0;
    nxt(); valid_i = 1; ecall_i = 1; pc_i = 32'h600; mtvec_i = 32'h400;
    for (int i = 0; i < 9; i++) begin
      if (i > 0) nxt();
      #1;
      reqs[i] = excRequest_o;
      if (stall_o === 1'b1) nstall++;
    end
    nxt(); idle_inputs();
    repeat (3) nxt();
    checks++;
    if (reqs !== 9'b010010010) begin
      failures++; $display("FAIL b2b_spacing request cycles=%b want 010010010", reqs);
    end
    checks++;
    if (nstall != 9) begin failures++; $display("FAIL b2b_stall stall cycles=%0d want 9", nstall); end
  endtask

  task automatic test_random();
    exp_t        q[$];
    exp_t        cur;
    logic [SYNC-1:0] h;
    logic        busy, acc, is_trap;
    logic [31:0] cause, tgt, e_cause, e_epc;
    nxt(); rst = 1; idle_inputs(); ext_irq_i = 0; #1;
    q.delete(); h = '0;
    for (int t = 0; t < 800; t++) begin
      nxt();
      rst = ($urandom_range(99) == 0);
      valid_i = ($urandom_range(9) < 7);
      pc_i = $urandom;
      instr_misaligned_i = ($urandom_range(9) == 0);
      illegal_i = ($urandom_range(7) == 0);
      ebreak_i = ($urandom_range(7) == 0);
      ecall_i = ($urandom_range(7) == 0);
      mret_i = ($urandom_range(4) == 0);
      if ($urandom_range(7) == 0) ext_irq_i = ~ext_irq_i;
      mstatus_mie_i = ($urandom_range(3) != 0);
      mie_meie_i = ($urandom_range(3) != 0);
      mtvec_i = $urandom; mepc_i = $urandom;
      #1;
      if (rst) begin q.delete(); h = '0; continue; end

      cur = '0; busy = 0; acc = 0;
      if (q.size() > 0) begin cur = q.pop_front(); busy = 1; end
      if (!busy && valid_i) begin
        is_trap = 1; cause = '0;
        if (h[SYNC-1] && mstatus_mie_i && mie_meie_i) cause = 32'h8000_000B;
        else if (instr_misaligned_i) cause = 0;
        else if (illegal_i) cause = 2;
        else if (ebreak_i) cause = 3;
        else if (ecall_i) cause = 11;
        else is_trap = 0;
        if (is_trap) begin
          q.push_back('{req: 1'b1, mret: 1'b0, redir: 1'b0, is_ret: 1'b0, cause: cause, epc: pc_i});
          q.push_back('{req: 1'b0, mret: 1'b0, redir: 1'b1, is_ret: 1'b0, cause: cause, epc: 32'h0});
          acc = 1;
        end else if (mret_i) begin
          q.push_back('{req: 1'b0, mret: 1'b1, redir: 1'b1, is_ret: 1'b1, cause: 32'h0, epc: 32'h0});
          acc = 1;
        end
      end

      tgt = '0;
      if (cur.redir) begin
        if (cur.is_ret) tgt = mepc_i & 32'hFFFF_FFFC;
        else begin
          tgt = mtvec_i & 32'hFFFF_FFFC;
          if ((mtvec_i & 32'h3) == 32'h1 && cur.cause[31]) tgt = tgt + ((cur.cause & 32'h7FFF_FFFF) * 4);
        end
      end
      e_cause = cur.req ? cur.cause : 32'h0;
      e_epc   = cur.req ? cur.epc : 32'h0;

      checks++;
      if (stall_o !== (busy | acc)) begin
        failures++; $display("FAIL rand_stall t=%0d got %0b want %0b", t, stall_o, busy | acc);
      end
      checks++;
      if (excRequest_o !== cur.req || excCause_o !== e_cause || excPc_o !== e_epc) begin
        failures++; $display("FAIL rand_req t=%0d got %0b/%0h/%0h want %0b/%0h/%0h",
                             t, excRequest_o, excCause_o, excPc_o, cur.req, e_cause, e_epc);
      end
      checks++;
      if (mret_o !== cur.mret || redirect_o !== cur.redir || redirect_pc_o !== tgt) begin
        failures++; $display("FAIL rand_redirect t=%0d got mret=%0b redir=%0b rpc=%0h want %0b/%0b/%0h",
                             t, mret_o, redirect_o, redirect_pc_o, cur.mret, cur.redir, tgt);
      end
      h = {h[SYNC-2:0], ext_irq_i};
    end
    nxt(); idle_inputs(); rst = 0;
  endtask

  initial begin
    rst = 1; idle_inputs();
    ext_irq_i = 0; mstatus_mie_i = 0; mie_meie_i = 0; mtvec_i = '0; mepc_i = '0;
    test_reset();
    test_illegal();
    test_arbitration();
    test_vectored_irq();
    test_masked();
    test_return();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
